// File: rtl/tb_mem_arbiter.sv
// tb_mem_arbiter: shares the single tb_memory access port between an
// instruction-fetch requester (port 0) and a data requester (port 1).
// Optional feature macro: TB_MEM_ARB_RR_EN (round-robin on ties);
// when undefined, port 1 always wins ties (fixed priority).
// Ports:
//   write_clk, reset        clock shared with tb_memory; sync active-high reset
//   req/addr/wdata/acc_sz/we (0,1)  per-port request fields, held until ack
//   ack0/ack1, rdata0/rdata1 one-cycle completion pulse, registered read data
//   mem_inputs, mem_rdata   drive tb_memory.the_inputs / take read_data_out
//   busy                    an access is in flight (state != IDLE)

package tb_mem_pkg;

    localparam int TB_MEM_ADDR_W = 16;
    localparam int TB_MEM_DATA_W = 16;

    localparam logic cpu_data_acc_sz_8  = 1'b0;
    localparam logic cpu_data_acc_sz_16 = 1'b1;

    typedef struct packed {
        logic [TB_MEM_ADDR_W-1:0] read_addr_in;
        logic                     read_data_acc_sz;
        logic [TB_MEM_ADDR_W-1:0] write_addr_in;
        logic [TB_MEM_DATA_W-1:0] write_data_in;
        logic                     write_data_acc_sz;
        logic                     write_data_we;
    } tb_mem_inputs;

endpackage

module tb_mem_arbiter
    import tb_mem_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
) (
    input  logic              write_clk,
    input  logic              reset,
    input  logic              req0,
    input  logic              req1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    input  logic              acc_sz0,
    input  logic              acc_sz1,
    input  logic              we0,
    input  logic              we1,
    output logic              ack0,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output tb_mem_inputs      mem_inputs,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_DONE   = 2'd2;

    logic [1:0]        state;
    logic [1:0]        state_nxt;
    logic              gnt;
    logic              pick;
    logic              any_req;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic              lat_sz;
    logic              lat_we;
    logic [DATA_W-1:0] rd_cap;
    logic [DATA_W-1:0] rdata0_q;
    logic [DATA_W-1:0] rdata1_q;

    assign any_req = req0 | req1;

`ifdef TB_MEM_ARB_RR_EN
    // last_gnt starts at 1 so the first tie after reset goes to port 0.
    logic last_gnt;

    always_comb begin
        if (req0 && req1) begin
            pick = ~last_gnt;
        end else begin
            pick = req1;
        end
    end

    always_ff @(posedge write_clk) begin
        if (reset) begin
            last_gnt <= 1'b1;
        end else if (state == ST_IDLE && any_req) begin
            last_gnt <= pick;
        end
    end
`else
    // Port 1 (data) wins every tie; port 0 is picked only when alone.
    assign pick = req1;
`endif

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: begin
                if (any_req) begin
                    state_nxt = ST_ACCESS;
                end
            end
            ST_ACCESS: state_nxt = ST_DONE;
            ST_DONE:   state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // Byte reads keep only the addressed byte in the low half.
    always_comb begin
        if (lat_sz == cpu_data_acc_sz_8) begin
            rd_cap = {{(DATA_W-8){1'b0}}, mem_rdata[7:0]};
        end else begin
            rd_cap = mem_rdata;
        end
    end

    always_ff @(posedge write_clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            gnt       <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            lat_sz    <= 1'b0;
            lat_we    <= 1'b0;
            rdata0_q  <= '0;
            rdata1_q  <= '0;
        end else begin
            state <= state_nxt;
            if (state == ST_IDLE && any_req) begin
                gnt       <= pick;
                lat_addr  <= pick ? addr1  : addr0;
                lat_wdata <= pick ? wdata1 : wdata0;
                lat_sz    <= pick ? acc_sz1 : acc_sz0;
                lat_we    <= pick ? we1    : we0;
            end
            if (state == ST_ACCESS && !lat_we) begin
                if (gnt) begin
                    rdata1_q <= rd_cap;
                end else begin
                    rdata0_q <= rd_cap;
                end
            end
        end
    end

    // Memory port is quiet outside ACCESS; reset kills an in-flight write
    // before the edge at which tb_memory would commit it.
    always_comb begin
        mem_inputs = '0;
        if (state == ST_ACCESS) begin
            mem_inputs.read_addr_in      = lat_addr;
            mem_inputs.write_addr_in     = lat_addr;
            mem_inputs.read_data_acc_sz  = lat_sz;
            mem_inputs.write_data_acc_sz = lat_sz;
            mem_inputs.write_data_in     = lat_wdata;
            mem_inputs.write_data_we     = lat_we & ~reset;
        end
    end

    assign ack0   = (state == ST_DONE) && !gnt;
    assign ack1   = (state == ST_DONE) &&  gnt;
    assign rdata0 = rdata0_q;
    assign rdata1 = rdata1_q;
    assign busy   = (state != ST_IDLE);

endmodule

// File: tb/tb_tb_mem_arbiter.sv
// Bench for tb_mem_arbiter: directed vector table, multi-cycle corner
// sequences and a randomized two-requester run against a memory reference.

module tb_tb_mem_arbiter;
    import tb_mem_pkg::*;

    typedef struct {
        bit          port;
        bit          we;
        bit          sz;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] exp;
    } vec_t;

    logic         write_clk = 1'b0;
    logic         reset;
    logic         req_v   [2];
    logic [15:0]  addr_v  [2];
    logic [15:0]  wdata_v [2];
    logic         sz_v    [2];
    logic         we_v    [2];
    logic         ack0;
    logic         ack1;
    logic [15:0]  rdata0;
    logic [15:0]  rdata1;
    tb_mem_inputs mem_inputs;
    logic [15:0]  mem_rdata;
    logic         busy;

    logic [7:0]   mem [0:65535];
    logic         poke_en;
    logic [15:0]  poke_addr;
    logic [7:0]   poke_data;
    logic [15:0]  ra;
    logic [15:0]  ra1;
    logic [15:0]  wa;
    logic [15:0]  wa1;

    logic [7:0]   ref_mem [0:255];
    vec_t         vecs [12];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 write_clk = ~write_clk;

    tb_mem_arbiter #(.ADDR_W(16), .DATA_W(16)) dut (
        .write_clk (write_clk),
        .reset     (reset),
        .req0      (req_v[0]),
        .req1      (req_v[1]),
        .addr0     (addr_v[0]),
        .addr1     (addr_v[1]),
        .wdata0    (wdata_v[0]),
        .wdata1    (wdata_v[1]),
        .acc_sz0   (sz_v[0]),
        .acc_sz1   (sz_v[1]),
        .we0       (we_v[0]),
        .we1       (we_v[1]),
        .ack0      (ack0),
        .ack1      (ack1),
        .rdata0    (rdata0),
        .rdata1    (rdata1),
        .mem_inputs(mem_inputs),
        .mem_rdata (mem_rdata),
        .busy      (busy)
    );

    // tb_memory stand-in: big-endian 16-bit pairs; a byte read returns the
    // addressed byte low and its neighbour high, so the arbiter must clear it.
    assign ra  = mem_inputs.read_addr_in;
    assign ra1 = ra + 16'd1;
    assign wa  = mem_inputs.write_addr_in;
    assign wa1 = wa + 16'd1;

    always_comb begin
        mem_rdata = '0;
        if (mem_inputs.read_data_acc_sz) begin
            mem_rdata = {mem[ra], mem[ra1]};
        end else begin
            mem_rdata = {mem[ra1], mem[ra]};
        end
    end

    always @(posedge write_clk) begin
        if (poke_en) begin
            mem[poke_addr] <= poke_data;
        end else if (mem_inputs.write_data_we) begin
            if (mem_inputs.write_data_acc_sz) begin
                mem[wa]  <= mem_inputs.write_data_in[15:8];
                mem[wa1] <= mem_inputs.write_data_in[7:0];
            end else begin
                mem[wa]  <= mem_inputs.write_data_in[7:0];
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge write_clk);
        #1;
    endtask

    function automatic logic ack_of(input int p);
        return (p == 0) ? ack0 : ack1;
    endfunction

    function automatic logic [15:0] rdata_of(input int p);
        return (p == 0) ? rdata0 : rdata1;
    endfunction

    task automatic poke(input logic [15:0] a, input logic [7:0] d);
        poke_en   = 1'b1;
        poke_addr = a;
        poke_data = d;
        tick();
        poke_en   = 1'b0;
    endtask

    task automatic reset_dut();
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            req_v[i]   = 1'b0;
            addr_v[i]  = '0;
            wdata_v[i] = '0;
            sz_v[i]    = 1'b0;
            we_v[i]    = 1'b0;
        end
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic set_req(input int p, input bit we, input bit sz,
                           input logic [15:0] a, input logic [15:0] d);
        req_v[p]   = 1'b1;
        we_v[p]    = we;
        sz_v[p]    = sz;
        addr_v[p]  = a;
        wdata_v[p] = d;
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int  p;
        int  c;
        bit  got;
        p   = int'(v.port);
        got = 1'b0;
        set_req(p, v.we, v.sz, v.addr, v.wdata);
        for (c = 1; c <= 8; c++) begin
            tick();
            if (c == 1) begin
                chk($sformatf("v%0d_busy", idx), busy, 1);
                chk($sformatf("v%0d_we", idx), mem_inputs.write_data_we, v.we);
                chk($sformatf("v%0d_raddr", idx), mem_inputs.read_addr_in, v.addr);
                chk($sformatf("v%0d_waddr", idx), mem_inputs.write_addr_in, v.addr);
                chk($sformatf("v%0d_wdata", idx), mem_inputs.write_data_in, v.wdata);
                chk($sformatf("v%0d_rsz", idx), mem_inputs.read_data_acc_sz, v.sz);
                chk($sformatf("v%0d_wsz", idx), mem_inputs.write_data_acc_sz, v.sz);
            end
            chk($sformatf("v%0d_other_ack", idx), ack_of(1 - p), 0);
            if (ack_of(p)) begin
                got = 1'b1;
                break;
            end
        end
        chk($sformatf("v%0d_latency", idx), got ? c : 99, 2);
        chk($sformatf("v%0d_rdata", idx), rdata_of(p), v.exp);
        chk($sformatf("v%0d_we_done", idx), mem_inputs.write_data_we, 0);
        req_v[p] = 1'b0;
        tick();
        chk($sformatf("v%0d_ack_clear", idx), ack_of(p), 0);
        chk($sformatf("v%0d_idle", idx), busy, 0);
    endtask

    initial begin
        int          exp_p [4];
        int          drop1_at;
        int          n;
        int          last;
        logic [15:0] b2b_addr [3];
        logic [15:0] b2b_exp  [3];
        bit          pend [2];
        int          rcyc [2];
        logic [15:0] last_rd [2];
        int          bound;
        logic [15:0] e;
        logic [7:0]  a8;

        // port, we, sz(1=16b), addr, wdata, expected rdata of that port
        vecs[0]  = '{0, 0, 1, 16'h0010, 16'h0000, 16'hABCD};
        vecs[1]  = '{1, 1, 0, 16'h0123, 16'h005A, 16'h0000};
        vecs[2]  = '{1, 0, 0, 16'h0123, 16'h0000, 16'h005A};
        vecs[3]  = '{1, 0, 0, 16'h0124, 16'h0000, 16'h0077};
        vecs[4]  = '{0, 1, 1, 16'h0020, 16'h1234, 16'hABCD};
        vecs[5]  = '{0, 0, 1, 16'h0020, 16'h0000, 16'h1234};
        vecs[6]  = '{1, 0, 1, 16'h0020, 16'h0000, 16'h1234};
        vecs[7]  = '{0, 0, 0, 16'h0021, 16'h0000, 16'h0034};
        vecs[8]  = '{1, 1, 1, 16'h0030, 16'hBEEF, 16'h1234};
        vecs[9]  = '{0, 0, 0, 16'h0030, 16'h0000, 16'h00BE};
        vecs[10] = '{1, 0, 1, 16'h0030, 16'h0000, 16'hBEEF};
        vecs[11] = '{0, 0, 1, 16'h0010, 16'h0000, 16'hABCD};

        poke_en   = 1'b0;
        poke_addr = '0;
        poke_data = '0;
        reset_dut();

        chk("rst_ack0", ack0, 0);
        chk("rst_ack1", ack1, 0);
        chk("rst_rdata0", rdata0, 0);
        chk("rst_rdata1", rdata1, 0);
        chk("rst_busy", busy, 0);
        chk("rst_mem_inputs", mem_inputs, 0);

        poke(16'h0010, 8'hAB);
        poke(16'h0011, 8'hCD);
        poke(16'h0124, 8'h77);
        poke(16'h0125, 8'h99);
        poke(16'h0002, 8'h9A);
        poke(16'h0003, 8'hBC);
        poke(16'h0200, 8'h11);
        poke(16'h0201, 8'h22);

        for (int i = 0; i < 12; i++) begin
            run_vec(i, vecs[i]);
        end
        chk("byte_wr_neighbour", mem[16'h0124], 8'h77);

        // Both ports requesting continuously from reset.
        reset_dut();
`ifdef TB_MEM_ARB_RR_EN
        exp_p    = '{0, 1, 0, 1};
        drop1_at = -1;
`else
        exp_p    = '{1, 1, 0, 0};
        drop1_at = 1;
`endif
        set_req(0, 1'b0, 1'b1, 16'h0010, 16'h0000);
        set_req(1, 1'b0, 1'b1, 16'h0020, 16'h0000);
        n    = 0;
        last = 0;
        for (int c = 1; c <= 30 && n < 4; c++) begin
            tick();
            if (ack0 || ack1) begin
                chk($sformatf("sim_port%0d", n), ack1, exp_p[n]);
                chk($sformatf("sim_onehot%0d", n), ack0 & ack1, 0);
                chk($sformatf("sim_gap%0d", n), c - last, (n == 0) ? 2 : 3);
                chk($sformatf("sim_rdata%0d", n),
                    ack1 ? rdata1 : rdata0,
                    ack1 ? 16'h1234 : 16'hABCD);
                last = c;
                if (n == drop1_at) begin
                    req_v[1] = 1'b0;
                end
                n++;
            end
        end
        chk("sim_count", n, 4);
        req_v[0] = 1'b0;
        req_v[1] = 1'b0;
        tick();

        // Reset lands while a write is in ACCESS.
        set_req(1, 1'b1, 1'b1, 16'h0200, 16'hBEEF);
        tick();
        chk("rst_acc_busy", busy, 1);
        chk("rst_acc_we_pre", mem_inputs.write_data_we, 1);
        reset = 1'b1;
        #1;
        chk("rst_acc_we_gated", mem_inputs.write_data_we, 0);
        tick();
        chk("rst_acc_no_ack", ack1, 0);
        chk("rst_acc_busy_after", busy, 0);
        reset    = 1'b0;
        req_v[1] = 1'b0;
        tick();
        chk("rst_acc_no_ack2", ack1, 0);
        chk("rst_acc_mem0", mem[16'h0200], 8'h11);
        chk("rst_acc_mem1", mem[16'h0201], 8'h22);

        // Back-to-back on port 0 with req held across ack.
        b2b_addr = '{16'h0010, 16'h0002, 16'h0020};
        b2b_exp  = '{16'hABCD, 16'h9ABC, 16'h1234};
        set_req(0, 1'b0, 1'b1, b2b_addr[0], 16'h0000);
        n    = 0;
        last = 0;
        for (int c = 1; c <= 20 && n < 3; c++) begin
            tick();
            if (ack0) begin
                chk($sformatf("b2b_gap%0d", n), c - last, (n == 0) ? 2 : 3);
                chk($sformatf("b2b_rdata%0d", n), rdata0, b2b_exp[n]);
                last = c;
                n++;
                if (n < 3) begin
                    addr_v[0] = b2b_addr[n];
                end else begin
                    req_v[0] = 1'b0;
                end
            end
        end
        chk("b2b_count", n, 3);
        tick();

        // Reset during DONE: ack falls at the reset edge.
        set_req(0, 1'b0, 1'b1, 16'h0002, 16'h0000);
        tick();
        tick();
        chk("rst_done_ack", ack0, 1);
        reset = 1'b1;
        tick();
        chk("rst_done_ack_drop", ack0, 0);
        chk("rst_done_busy", busy, 0);
        chk("rst_done_rdata0", rdata0, 0);
        reset    = 1'b0;
        req_v[0] = 1'b0;

        // Randomized traffic from both requesters.
        reset_dut();
        for (int a = 16'h40; a <= 16'h50; a++) begin
            a8 = 8'($urandom);
            ref_mem[a] = a8;
            poke(16'(a), a8);
        end
`ifdef TB_MEM_ARB_RR_EN
        bound = 8;
`else
        bound = 300;
`endif
        for (int p = 0; p < 2; p++) begin
            pend[p]    = 1'b0;
            rcyc[p]    = 0;
            last_rd[p] = 16'h0000;
        end
        for (int cyc = 0; cyc < 3030; cyc++) begin
            tick();
            chk("rnd_onehot", ack0 & ack1, 0);
            chk("rnd_we_busy", mem_inputs.write_data_we & ~busy, 0);
            for (int p = 0; p < 2; p++) begin
                if (ack_of(p)) begin
                    chk($sformatf("rnd_ack_pending_p%0d", p), pend[p], 1);
                    if (pend[p]) begin
                        chk($sformatf("rnd_latency_p%0d", p),
                            (cyc - rcyc[p]) >= 2, 1);
                        a8 = addr_v[p][7:0];
                        if (we_v[p]) begin
                            if (sz_v[p]) begin
                                ref_mem[a8]      = wdata_v[p][15:8];
                                ref_mem[a8 + 1]  = wdata_v[p][7:0];
                            end else begin
                                ref_mem[a8]      = wdata_v[p][7:0];
                            end
                            chk($sformatf("rnd_wr_hold_p%0d", p),
                                rdata_of(p), last_rd[p]);
                        end else begin
                            if (sz_v[p]) begin
                                e = {ref_mem[a8], ref_mem[a8 + 1]};
                            end else begin
                                e = {8'h00, ref_mem[a8]};
                            end
                            last_rd[p] = e;
                            chk($sformatf("rnd_rd_p%0d", p), rdata_of(p), e);
                        end
                    end
                    pend[p]  = 1'b0;
                    req_v[p] = 1'b0;
                end else if (pend[p] && (cyc - rcyc[p]) > bound) begin
                    chk($sformatf("rnd_timeout_p%0d", p), cyc - rcyc[p], bound);
                    pend[p]  = 1'b0;
                    req_v[p] = 1'b0;
                end
                if (!pend[p] && cyc < 3000 && $urandom_range(0, 1) == 1) begin
                    set_req(p, $urandom_range(0, 2) == 0,
                            1'($urandom_range(0, 1)),
                            16'h0040 + 16'($urandom_range(0, 15)),
                            16'($urandom));
                    pend[p] = 1'b1;
                    rcyc[p] = cyc;
                end
            end
        end
        chk("rnd_drain_p0", pend[0], 0);
        chk("rnd_drain_p1", pend[1], 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
